// File: rtl/dft_pkg.sv
// Shared types for the DFT address sequencer: mode encoding, FSM states, default width.
package dft_pkg;

    localparam int unsigned ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        MODE_LINEAR     = 2'd0,
        MODE_TRANSPOSE2 = 2'd1,
        MODE_REVERSE3   = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dft_addr_seq_if.sv
// Control and address-stream bundle between a requester and dft_addr_seq.
interface dft_addr_seq_if #(
    parameter int unsigned ADDR_W = dft_pkg::ADDR_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] f0;
    logic [ADDR_W-1:0] f1;
    logic [ADDR_W-1:0] f2;
    logic [1:0]        mode;
    logic              ready;
    logic              addr_valid;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, f0, f1, f2, mode, ready,
        input  addr_valid, addr, last, busy, done, cfg_err
    );

    modport slave (
        input  start, f0, f1, f2, mode, ready,
        output addr_valid, addr, last, busy, done, cfg_err
    );

endinterface

// File: rtl/mixed_radix_counter.sv
// Three-digit mixed-radix counter; digit 0 is fastest, limit-1 digits carry straight through.
module mixed_radix_counter
    import dft_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              advance,
    input  logic [ADDR_W-1:0] lim0,
    input  logic [ADDR_W-1:0] lim1,
    input  logic [ADDR_W-1:0] lim2,
    output logic              carry0_c,
    output logic              carry1_c,
    output logic              wrap_c
);

    logic [ADDR_W-1:0] d0_q;
    logic [ADDR_W-1:0] d1_q;
    logic [ADDR_W-1:0] d2_q;

    // A digit is at its maximum when it equals limit-1; a limit of 1 is always at maximum.
    assign carry0_c = (d0_q == ADDR_W'(lim0 - ADDR_W'(1)));
    assign carry1_c = carry0_c && (d1_q == ADDR_W'(lim1 - ADDR_W'(1)));
    assign wrap_c   = carry1_c && (d2_q == ADDR_W'(lim2 - ADDR_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
        end else if (clr) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
        end else if (advance) begin
            d0_q <= carry0_c ? '0 : ADDR_W'(d0_q + ADDR_W'(1));
            if (carry0_c) begin
                d1_q <= carry1_c ? '0 : ADDR_W'(d1_q + ADDR_W'(1));
            end
            if (carry1_c) begin
                d2_q <= wrap_c ? '0 : ADDR_W'(d2_q + ADDR_W'(1));
            end
        end
    end

endmodule

// File: rtl/dft_addr_seq.sv
// Mixed-radix DFT address sequencer (LINEAR / TRANSPOSE2 / REVERSE3 orders).
// Optional configuration checking is enabled with macro DFT_ADDR_SEQ_BOUND_CHECK_EN.
module dft_addr_seq
    import dft_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dft_addr_seq_if.slave bus
);

    localparam int unsigned PW2 = 2 * ADDR_W;
    localparam int unsigned PW3 = 3 * ADDR_W;

    state_e            state;
    state_e            state_nx;
    logic [ADDR_W-1:0] f0_q;
    logic [ADDR_W-1:0] f1_q;
    logic [ADDR_W-1:0] f2_q;
    mode_e             mode_q;
    logic [ADDR_W-1:0] s0_q;
    logic [ADDR_W-1:0] s1_q;
    logic [ADDR_W-1:0] s2_q;
    logic [ADDR_W-1:0] base1_q;
    logic [ADDR_W-1:0] base2_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PW3-1:0]    rem_q;
    logic              last_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic [PW2-1:0]    p01_c;
    logic [ADDR_W-1:0] p12_c;
    logic [PW3-1:0]    n_c;
    logic              cfg_bad_c;
    logic              accept_c;
    logic              carry0_c;
    logic              carry1_c;
    logic              wrap_c;

    // Multipliers only feed the LOAD-cycle register updates; RUN uses adders alone.
    assign p01_c = PW2'(f0_q) * PW2'(f1_q);
    assign p12_c = f1_q * f2_q;
    assign n_c   = PW3'(p01_c) * PW3'(f2_q);

    assign accept_c = valid_q && bus.ready;

`ifdef DFT_ADDR_SEQ_BOUND_CHECK_EN
    localparam logic [PW3-1:0] N_MAX = PW3'(1) << ADDR_W;

    logic cfg_err_q;

    assign cfg_bad_c = (f0_q == '0) || (f1_q == '0) || (f2_q == '0) ||
                       (n_c > N_MAX) || (mode_q == MODE_RSVD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state == ST_LOAD) && cfg_bad_c;
        end
    end

    assign bus.cfg_err = cfg_err_q;
`else
    assign cfg_bad_c   = 1'b0;
    assign bus.cfg_err = 1'b0;
`endif

    mixed_radix_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_RUN),
        .advance  (accept_c),
        .lim0     (f0_q),
        .lim1     (f1_q),
        .lim2     (f2_q),
        .carry0_c (carry0_c),
        .carry1_c (carry1_c),
        .wrap_c   (wrap_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_LOAD;
            ST_LOAD: state_nx = cfg_bad_c ? ST_IDLE : ST_RUN;
            ST_RUN:  if (accept_c && last_q) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sequencing datapath: config latch, LOAD-time strides, incremental address in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f0_q    <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            mode_q  <= MODE_LINEAR;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            base1_q <= '0;
            base2_q <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= (state_nx == ST_RUN);
            busy_q  <= (state_nx != ST_IDLE);
            done_q  <= (state_nx == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        f0_q   <= bus.f0;
                        f1_q   <= bus.f1;
                        f2_q   <= bus.f2;
                        mode_q <= mode_e'(bus.mode);
                    end
                end
                ST_LOAD: begin
                    case (mode_q)
                        MODE_TRANSPOSE2: begin
                            s0_q <= p12_c;
                            s1_q <= ADDR_W'(1);
                            s2_q <= f1_q;
                        end
                        MODE_REVERSE3: begin
                            s0_q <= p12_c;
                            s1_q <= f2_q;
                            s2_q <= ADDR_W'(1);
                        end
                        default: begin
                            s0_q <= ADDR_W'(1);
                            s1_q <= f0_q;
                            s2_q <= ADDR_W'(p01_c);
                        end
                    endcase
                    base1_q <= '0;
                    base2_q <= '0;
                    addr_q  <= '0;
                    rem_q   <= PW3'(n_c - PW3'(1));
                    last_q  <= (n_c == PW3'(1));
                end
                ST_RUN: begin
                    if (accept_c) begin
                        rem_q  <= PW3'(rem_q - PW3'(1));
                        last_q <= (rem_q == PW3'(1));
                        if (!carry0_c) begin
                            addr_q <= ADDR_W'(addr_q + s0_q);
                        end else if (!carry1_c) begin
                            base1_q <= ADDR_W'(base1_q + s1_q);
                            addr_q  <= ADDR_W'(base1_q + s1_q);
                        end else if (!wrap_c) begin
                            base2_q <= ADDR_W'(base2_q + s2_q);
                            base1_q <= ADDR_W'(base2_q + s2_q);
                            addr_q  <= ADDR_W'(base2_q + s2_q);
                        end else begin
                            addr_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr_valid = valid_q;
    assign bus.addr       = addr_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_dft_addr_seq.sv
// Directed bench for dft_addr_seq; extra checks run when DFT_ADDR_SEQ_BOUND_CHECK_EN is defined.
module tb_dft_addr_seq;

    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst;
    int   n_asrt = 0;
    int   n_fail = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    dft_addr_seq_if #(.ADDR_W(AW)) bus ();
    dft_addr_seq #(.ADDR_W(AW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DFT_ADDR_SEQ_BOUND_CHECK_EN
    dft_addr_seq_if #(.ADDR_W(11)) bus11 ();
    dft_addr_seq #(.ADDR_W(11)) u_dut11 (.clk(clk), .rst(rst), .bus(bus11));
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_addr(int m, int a, int b, int c, int d0, int d1, int d2);
        case (m)
            1:       return d0 * (b * c) + d1 + d2 * b;
            2:       return d0 * b * c + d1 * c + d2;
            default: return d0 + d1 * a + d2 * a * b;
        endcase
    endfunction

    task automatic build(input int m, input int a, input int b, input int c);
        exp_q.delete();
        for (int d2 = 0; d2 < c; d2++)
            for (int d1 = 0; d1 < b; d1++)
                for (int d0 = 0; d0 < a; d0++)
                    exp_q.push_back(model_addr(m, a, b, c, d0, d1, d2));
    endtask

    // Pulse start with a config, then scramble the inputs to prove they were latched.
    task automatic kick(input int a, input int b, input int c, input int m);
        bus.f0    = AW'(a);
        bus.f1    = AW'(b);
        bus.f2    = AW'(c);
        bus.mode  = 2'(m);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.f0    = AW'(7);
        bus.f1    = AW'(7);
        bus.f2    = AW'(7);
        step();
    endtask

    // pat 0: ready always high; pat 1: ready cycles 1,0,0,1. poke re-pulses start mid-run.
    task automatic consume(input int pat, input bit poke);
        int idx = 0;
        int cyc = 0;
        int n   = exp_q.size();
        chk("first_valid", 64'(bus.addr_valid), 64'(1));
        while (idx < n && cyc < 2000) begin
            bus.ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            bus.start = poke && (cyc == 3);
            chk("valid_run", 64'(bus.addr_valid), 64'(1));
            chk("done_early", 64'(bus.done), 64'(0));
            if (bus.addr_valid) begin
                chk(bus.ready ? "addr" : "addr_hold", 64'(bus.addr), 64'(exp_q[idx]));
                chk("last", 64'(bus.last), 64'(idx == n - 1));
                if (bus.ready) idx++;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0;
        if (idx < n) chk("timeout", 64'(idx), 64'(n));
        if (pat == 0) chk("no_bubble_cycles", 64'(cyc), 64'(n));
        chk("done_pulse", 64'(bus.done), 64'(1));
        chk("valid_after", 64'(bus.addr_valid), 64'(0));
        chk("busy_done", 64'(bus.busy), 64'(1));
        step();
        chk("done_drop", 64'(bus.done), 64'(0));
        chk("busy_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int vseen;
        bit seen[30];
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        bus.f0    = '0;
        bus.f1    = '0;
        bus.f2    = '0;
        bus.mode  = '0;
`ifdef DFT_ADDR_SEQ_BOUND_CHECK_EN
        bus11.start = 1'b0;
        bus11.ready = 1'b1;
        bus11.f0    = '0;
        bus11.f1    = '0;
        bus11.f2    = '0;
        bus11.mode  = '0;
`endif
        repeat (3) step();
        chk("rst_valid", 64'(bus.addr_valid), 64'(0));
        chk("rst_addr", 64'(bus.addr), 64'(0));
        chk("rst_last", 64'(bus.last), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'(0));
        rst = 1'b0;
        step();

        // TRANSPOSE2 4x3x1, hand-computed order
        exp_q = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        bus.ready = 1'b1;
        kick(4, 3, 1, 1);
        consume(0, 1'b0);

        // REVERSE3 2x3x5: prefix by hand, full set uniqueness
        build(2, 2, 3, 5);
        chk("rev3_q1", 64'(exp_q[1]), 64'(15));
        chk("rev3_q2", 64'(exp_q[2]), 64'(5));
        chk("rev3_q6", 64'(exp_q[6]), 64'(1));
        vseen = 0;
        foreach (exp_q[i]) if (exp_q[i] < 30 && !seen[exp_q[i]]) begin seen[exp_q[i]] = 1'b1; vseen++; end
        chk("rev3_set", 64'(vseen), 64'(30));
        kick(2, 3, 5, 2);
        consume(0, 1'b0);

        // LINEAR 4x3x5 with throttled ready: 0..59 in order
        exp_q.delete();
        for (int i = 0; i < 60; i++) exp_q.push_back(i);
        kick(4, 3, 5, 0);
        consume(1, 1'b0);

        // N == 1: single address, last on first valid cycle
        exp_q = '{0};
        kick(1, 1, 1, 2);
        consume(0, 1'b0);

        // start re-pulsed during RUN is ignored
        build(1, 4, 3, 1);
        kick(4, 3, 1, 1);
        consume(0, 1'b1);

        // rst mid-RUN at the fifth address, then restart from 0
        kick(4, 3, 1, 0);
        bus.ready = 1'b1;
        repeat (4) step();
        chk("pre_rst_addr", 64'(bus.addr), 64'(4));
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.addr_valid), 64'(0));
        chk("midrst_addr", 64'(bus.addr), 64'(0));
        chk("midrst_last", 64'(bus.last), 64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        step();
        rst = 1'b0;
        repeat (4) begin
            step();
            chk("no_done_after_rst", 64'(bus.done), 64'(0));
        end
        build(0, 4, 3, 1);
        kick(4, 3, 1, 0);
        consume(0, 1'b0);

`ifdef DFT_ADDR_SEQ_BOUND_CHECK_EN
        // N=2880 exceeds 2^11
        bus11.f0    = 11'd64;
        bus11.f1    = 11'd9;
        bus11.f2    = 11'd5;
        bus11.mode  = 2'd0;
        bus11.start = 1'b1;
        step();
        bus11.start = 1'b0;
        vseen = 0;
        step();
        if (bus11.addr_valid) vseen++;
        chk("ovf_cfg_err", 64'(bus11.cfg_err), 64'(1));
        chk("ovf_busy", 64'(bus11.busy), 64'(0));
        repeat (4) begin
            step();
            if (bus11.addr_valid) vseen++;
        end
        chk("ovf_cfg_err_pulse", 64'(bus11.cfg_err), 64'(0));
        chk("ovf_never_valid", 64'(vseen), 64'(0));

        // reserved mode and zero factor are rejected
        bus.f0 = AW'(2); bus.f1 = AW'(2); bus.f2 = AW'(1); bus.mode = 2'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("mode3_cfg_err", 64'(bus.cfg_err), 64'(1));
        chk("mode3_valid", 64'(bus.addr_valid), 64'(0));
        step();
        bus.f0 = AW'(0); bus.mode = 2'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("zero_cfg_err", 64'(bus.cfg_err), 64'(1));
        chk("zero_busy", 64'(bus.busy), 64'(0));
        step();
`else
        // reserved mode falls back to LINEAR and cfg_err stays low
        build(0, 2, 3, 1);
        kick(2, 3, 1, 3);
        chk("mode3_cfg_err", 64'(bus.cfg_err), 64'(0));
        consume(0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/dft_addr_seq.md
DFT_ADDR_SEQ -- requirements
Module: dft_addr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: width of factor and address ports; maximum supported point count is 2^ADDR_W.
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-005 SHALL have ports f0, f1, f2  input  ADDR_W each  radix factors (pow2, pow3, pow5); latched on accepted start.
REQ-006 SHALL have port mode  input  2  order: 0 LINEAR, 1 TRANSPOSE2, 2 REVERSE3, 3 reserved.
REQ-007 SHALL have port ready  input  1  downstream accepts addr this cycle.
REQ-008 SHALL have port addr_valid  output  1  addr is valid.
REQ-009 SHALL have port addr  output  ADDR_W  current address.
REQ-010 SHALL have port last  output  1  addr is the final address of the sequence; qualified by addr_valid.
REQ-011 SHALL have port busy  output  1  high from LOAD through DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse when start carries an illegal configuration.

Function
REQ-014 SHALL implement FSM IDLE->LOAD->RUN->DONE->IDLE; LOAD->IDLE on an illegal configuration.
REQ-015 SHALL, on start in IDLE, latch f0/f1/f2/mode and enter LOAD the next cycle; start outside IDLE SHALL be ignored.
REQ-016 SHALL in LOAD compute N=f0*f1*f2 and the strides f0*f1 and f1*f2 in full precision (2*ADDR_W+ bits), with no multiplier in the RUN path.
REQ-017 SHALL iterate digits d0<f0 (fastest), d1<f1, d2<f2, n=0..N-1, using a carry-chained mixed-radix counter.
REQ-018 SHALL output addr per mode: LINEAR = d0+d1*f0+d2*f0*f1; TRANSPOSE2 = d0*(f1*f2)+d1+d2*f1; REVERSE3 = d0*f1*f2+d1*f2+d2.
REQ-019 SHALL maintain addr incrementally: add the digit stride on d0 advance; on carry, rebase to the accumulated higher-digit offset.
REQ-020 SHALL assert addr_valid for the whole of RUN, with the first valid addr (value 0) two cycles after start.
REQ-021 SHALL advance to the next address only on addr_valid&&ready; with ready low, addr and last SHALL hold.
REQ-022 SHALL assert last when n==N-1; after last is accepted, SHALL enter DONE, pulse done for one cycle, and return to IDLE; busy SHALL fall with the IDLE entry.
REQ-023 SHALL emit N addresses in N cycles when ready is held high, with no bubbles at digit wrap.
REQ-024 SHALL treat a factor value of 1 as a degenerate digit (always 0), with carry passing through in the same cycle.
REQ-025 SHALL, for N==1, emit addr 0 with last=1 on the first valid cycle.

Reset
REQ-026 SHALL, on rst, drive addr_valid, addr, last, busy, done and cfg_err to 0, enter IDLE, and clear all counters, regardless of current state.
REQ-027 SHALL, on rst asserted mid-RUN, produce no done pulse; the next sequence SHALL start from addr 0.

Configuration
REQ-028 SHALL, with macro DFT_ADDR_SEQ_BOUND_CHECK_EN defined, check the configuration in LOAD: any factor==0, N>2^ADDR_W, or mode==3 SHALL pulse cfg_err, return to IDLE, and assert neither addr_valid nor busy beyond LOAD.
REQ-029 SHALL, without DFT_ADDR_SEQ_BOUND_CHECK_EN, tie cfg_err to 0, treat mode 3 as LINEAR, truncate addr to ADDR_W bits, and leave behaviour for a zero factor undefined.

Structure
REQ-030 SHALL take the mode encoding enum, the FSM state enum and the ADDR_W default from shared package dft_pkg.
REQ-031 SHALL instantiate exactly one sub-module, mixed_radix_counter (three digits, per-digit limit inputs, advance input, carry/wrap outputs).

Verification
REQ-032 SHALL verify: f0=4,f1=3,f2=1,mode=1,ready=1 -> addr 0,3,6,9,1,4,7,10,2,5,8,11; last on 11; done the next cycle.
REQ-033 SHALL verify: f0=2,f1=3,f2=5,mode=2 -> 30 addresses starting 0,15,5,20,10,25,1,16,...; set equals 0..29 with no repeats.
REQ-034 SHALL verify: mode=0, f0=4,f1=3,f2=5, ready toggling 1,0,0,1 -> addr holds while ready=0; 60 addresses in order 0..59.
REQ-035 SHALL verify: with BOUND_CHECK_EN and ADDR_W=11, f0=64,f1=9,f2=5 (N=2880) -> cfg_err pulse, addr_valid never high.
REQ-036 SHALL verify: rst pulsed at the 5th address, then restart -> outputs 0 during rst, no done, new run begins at addr 0.
REQ-037 SHALL verify: start re-pulsed during RUN -> ignored; sequence and done timing unchanged.
